// File: rtl/iq_bypass_wakeup.sv
// rtl/iq_bypass_wakeup.sv - compacting issue queue with ALU0/BRU bypass wakeup and oldest-first select
//
// Purpose: holds up to DEPTH dispatched micro-ops. Each cycle it snoops the ALU0 and
// BRU bypass buses to capture waiting source operands. It issues the oldest entry
// whose two sources are both ready. Valid entries stay packed from slot 0, and slot 0
// holds the oldest entry.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             empties the queue at the next edge
//   disp_*            dispatch handshake (disp_vld/disp_rdy) and micro-op fields
//   ALU0_*/BRU_*      bypass buses; a tag of 0 means no write
//   iss_*             issue handshake (iss_vld/iss_rdy) and selected micro-op
//   count             number of occupied entries
module iq_bypass_wakeup #(
    parameter int DEPTH = 4,
    parameter int PRW   = 6,
    parameter int DW    = 32,
    parameter int OPW   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     disp_vld,
    output logic                     disp_rdy,
    input  logic [OPW-1:0]           disp_op,
    input  logic [PRW-1:0]           disp_dst_pr,
    input  logic [PRW-1:0]           disp_src1_pr,
    input  logic [PRW-1:0]           disp_src2_pr,
    input  logic                     disp_src1_rdy,
    input  logic                     disp_src2_rdy,
    input  logic [DW-1:0]            disp_src1_data,
    input  logic [DW-1:0]            disp_src2_data,
    input  logic [PRW-1:0]           ALU0_PR_bypass,
    input  logic [DW-1:0]            ALU0_data_bypass,
    input  logic [PRW-1:0]           BRU_PR_bypass,
    input  logic [DW-1:0]            BRU_data_bypass,
    output logic                     iss_vld,
    input  logic                     iss_rdy,
    output logic [OPW-1:0]           iss_op,
    output logic [PRW-1:0]           iss_dst_pr,
    output logic [DW-1:0]            iss_src1_data,
    output logic [DW-1:0]            iss_src2_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic [PRW-1:0] pr;
        logic           rdy;
        logic [DW-1:0]  data;
    } src_t;

    typedef struct packed {
        logic           vld;
        logic [OPW-1:0] op;
        logic [PRW-1:0] dst;
        src_t           s1;
        src_t           s2;
    } entry_t;

    entry_t         entry_q [DEPTH];
    entry_t         entry_d [DEPTH];
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_d;

    // One extra all-zero slot past the top, so the shift-down can read slot i+1 everywhere.
    entry_t         entry_ext [DEPTH+1];
    entry_t         disp_ent;
    logic           sel_found;
    logic [IW-1:0]  sel_idx;
    logic           iss_fire;
    logic           disp_fire;
    logic [CW-1:0]  wr_idx;

    // Capture a bypass result into a waiting source. Tag 0 never matches, and ALU0 has priority over BRU.
    function automatic src_t wake(input src_t s,
                                  input logic [PRW-1:0] a_pr, input logic [DW-1:0] a_d,
                                  input logic [PRW-1:0] b_pr, input logic [DW-1:0] b_d);
        src_t r;
        r = s;
        if (!s.rdy && s.pr != '0) begin
            if (s.pr == a_pr) begin
                r.rdy  = 1'b1;
                r.data = a_d;
            end else if (s.pr == b_pr) begin
                r.rdy  = 1'b1;
                r.data = b_d;
            end
        end
        return r;
    endfunction

    // Oldest-first select: scan from the top down so that the lowest ready index wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (entry_q[i].vld && entry_q[i].s1.rdy && entry_q[i].s2.rdy) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    assign disp_rdy  = !rst && !flush && (count_q != CW'(DEPTH));
    assign disp_fire = disp_vld && disp_rdy;
    assign iss_vld   = !rst && !flush && sel_found;
    assign iss_fire  = iss_vld && iss_rdy;
    assign count     = count_q;

    always_comb begin
        iss_op        = '0;
        iss_dst_pr    = '0;
        iss_src1_data = '0;
        iss_src2_data = '0;
        if (iss_vld) begin
            iss_op        = entry_q[sel_idx].op;
            iss_dst_pr    = entry_q[sel_idx].dst;
            iss_src1_data = entry_q[sel_idx].s1.data;
            iss_src2_data = entry_q[sel_idx].s2.data;
        end
    end

    // Incoming entry: a zero-tag source counts as ready with data 0. A waiting source can
    // still be woken in its dispatch cycle.
    always_comb begin
        disp_ent        = '0;
        disp_ent.vld    = 1'b1;
        disp_ent.op     = disp_op;
        disp_ent.dst    = disp_dst_pr;
        disp_ent.s1.pr  = disp_src1_pr;
        disp_ent.s2.pr  = disp_src2_pr;
        if (disp_src1_pr == '0) begin
            disp_ent.s1.rdy = 1'b1;
        end else if (disp_src1_rdy) begin
            disp_ent.s1.rdy  = 1'b1;
            disp_ent.s1.data = disp_src1_data;
        end
        if (disp_src2_pr == '0) begin
            disp_ent.s2.rdy = 1'b1;
        end else if (disp_src2_rdy) begin
            disp_ent.s2.rdy  = 1'b1;
            disp_ent.s2.data = disp_src2_data;
        end
        disp_ent.s1 = wake(disp_ent.s1, ALU0_PR_bypass, ALU0_data_bypass, BRU_PR_bypass, BRU_data_bypass);
        disp_ent.s2 = wake(disp_ent.s2, ALU0_PR_bypass, ALU0_data_bypass, BRU_PR_bypass, BRU_data_bypass);
    end

    // Next state for each slot: shift down past the issued entry, then apply wakeup in the
    // post-shift slot, then write the dispatch slot behind the survivors.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_ext[i] = entry_q[i];
        end
        entry_ext[DEPTH] = '0;
        wr_idx = count_q - CW'(iss_fire);
        for (int i = 0; i < DEPTH; i++) begin
            if (iss_fire && i >= int'(sel_idx)) begin
                entry_d[i] = entry_ext[i + 1];
            end else begin
                entry_d[i] = entry_ext[i];
            end
            if (entry_d[i].vld) begin
                entry_d[i].s1 = wake(entry_d[i].s1, ALU0_PR_bypass, ALU0_data_bypass,
                                     BRU_PR_bypass, BRU_data_bypass);
                entry_d[i].s2 = wake(entry_d[i].s2, ALU0_PR_bypass, ALU0_data_bypass,
                                     BRU_PR_bypass, BRU_data_bypass);
            end
            if (disp_fire && int'(wr_idx) == i) begin
                entry_d[i] = disp_ent;
            end
            if (flush) begin
                entry_d[i].vld = 1'b0;
            end
        end
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(disp_fire) - CW'(iss_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q <= '{default: '0};
            count_q <= '0;
        end else begin
            entry_q <= entry_d;
            count_q <= count_d;
        end
    end

endmodule
